// File: rtl/itch_pkg.sv
// Shared ITCH Add Order constants: message types, field offsets/lengths, error codes, FSM states.
// ADD_ORDER_MPID_EN adds the 'F' (Add Order with MPID) layout and its 30-byte staging area.
// Pure declarations; no timing or flow-control behaviour of its own.
package itch_pkg;

  localparam logic [7:0] MSG_ADD_ORDER = 8'h41;  // 'A'
  localparam logic [7:0] SIDE_BUY      = 8'h42;  // 'B'

  localparam int OFF_ORDER_REF = 1;
  localparam int LEN_ORDER_REF = 8;
  localparam int OFF_SIDE      = 9;
  localparam int OFF_SHARES    = 10;
  localparam int LEN_SHARES    = 4;
  localparam int OFF_STOCK     = 14;
  localparam int LEN_STOCK     = 8;
  localparam int OFF_PRICE     = 22;
  localparam int LEN_PRICE     = 4;
  localparam int ADD_ORDER_LEN = 26;

`ifdef ADD_ORDER_MPID_EN
  localparam logic [7:0] MSG_ADD_ORDER_MPID = 8'h46;  // 'F'
  localparam int OFF_MPID           = 26;
  localparam int LEN_MPID           = 4;
  localparam int ADD_ORDER_MPID_LEN = 30;
  localparam int STAGE_BYTES        = ADD_ORDER_MPID_LEN;
`else
  localparam int STAGE_BYTES        = ADD_ORDER_LEN;
`endif

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_LEN_MISMATCH = 2'd1,
    ERR_NO_LEN       = 2'd2,
    ERR_TRUNC        = 2'd3
  } err_code_t;

  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE   = 2'd0;
  localparam fsm_state_t ST_DECODE = 2'd1;
  localparam fsm_state_t ST_SKIP   = 2'd2;

endpackage

// File: rtl/itch_lane_scatter.sv
// One input lane: turns (beat base offset + lane index) into a one-hot staging byte write-enable.
// Purely combinational, zero latency.
// No flow control; the caller gates lane_en_i with beat acceptance.
module itch_lane_scatter
  import itch_pkg::*;
#(
  parameter int LANE  = 0,
  parameter int OFF_W = 6
) (
  input  logic [OFF_W-1:0]       base_i,
  input  logic                   lane_en_i,
  output logic [STAGE_BYTES-1:0] we_o
);

  // Widened so base + lane never wraps back into the staging range.
  localparam int POS_W = OFF_W + 4;

  logic [POS_W-1:0] pos;
  assign pos = POS_W'(base_i) + POS_W'(LANE);

  // Offsets past the staging area match no bit, so those bytes are dropped.
  always_comb begin
    for (int k = 0; k < STAGE_BYTES; k++) begin
      we_o[k] = lane_en_i && (pos == POS_W'(k));
    end
  end

endmodule

// File: rtl/add_order_decoder_mlane.sv
// Multi-lane ITCH Add Order decoder; stages bytes as they arrive, emits one checked record per message.
// Latency: record valid 1 cycle after the last accepted beat; errors pulse on that same cycle.
// Backpressure: in_ready = !out_valid || out_ready; build option ADD_ORDER_MPID_EN adds 'F' records.
module add_order_decoder_mlane
  import itch_pkg::*;
#(
  parameter int LANES = 2,
  parameter int OFF_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [8*LANES-1:0] in_data,
  input  logic [LANES-1:0]   in_keep,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_start,
  input  logic               in_last,
  input  logic               abort_in,
  input  logic [5:0]         len_value,
  input  logic               len_valid,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        out_order_ref,
  output logic               out_buy,
  output logic [31:0]        out_shares,
  output logic [63:0]        out_stock,
  output logic [31:0]        out_price,
`ifdef ADD_ORDER_MPID_EN
  output logic [31:0]        out_mpid,
  output logic               out_is_mpid,
`endif
  output logic               err_valid,
  output logic [1:0]         err_code
);

  localparam int TOT_W = OFF_W + 4;
  localparam logic [TOT_W-1:0] OFF_SAT = TOT_W'((2 ** OFF_W) - 1);

  fsm_state_t state_q, state_d, cur_st;
  logic [OFF_W-1:0] offset_q, offset_d, base, off_sum;
  logic             len_vld_q, len_vld_d, len_have;
  logic [5:0]       len_q, len_d, len_eff;
  logic [3:0]       nkeep;
  logic [TOT_W-1:0] total, exp_len;
  logic             live, start_acc, type_ok, dec_beat, last_dec, rec_load;
  err_code_t        err_d;
  logic [7:0]       stage_q [STAGE_BYTES];
  logic [7:0]       stage_d [STAGE_BYTES];
  logic [STAGE_BYTES-1:0] lane_we [LANES];
  logic [63:0] rec_ref, rec_stock, out_ref_q, out_stock_q;
  logic [31:0] rec_shares, rec_price, out_shares_q, out_price_q;
  logic        out_valid_q, out_buy_q, err_vld_q;
  logic [1:0]  err_code_q;

  assign in_ready  = !out_valid_q || out_ready;
  // An aborted beat is consumed but otherwise ignored.
  assign live      = in_valid && in_ready && !abort_in;
  assign start_acc = live && in_start;

`ifdef ADD_ORDER_MPID_EN
  logic        typf_q, typf_d, beat_is_f, out_is_mpid_q;
  logic [31:0] rec_mpid, out_mpid_q;
  assign beat_is_f = (in_data[7:0] == MSG_ADD_ORDER_MPID);
  assign type_ok   = (in_data[7:0] == MSG_ADD_ORDER) || beat_is_f;
  assign typf_d    = start_acc ? beat_is_f : typf_q;
  assign exp_len   = typf_d ? TOT_W'(ADD_ORDER_MPID_LEN) : TOT_W'(ADD_ORDER_LEN);

  // Remember which layout the current message uses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) typf_q <= 1'b0;
    else        typf_q <= typf_d;
  end
`else
  assign type_ok = (in_data[7:0] == MSG_ADD_ORDER);
  assign exp_len = TOT_W'(ADD_ORDER_LEN);
`endif

  // A start beat restarts decoding at offset 0 whatever state we were in.
  assign cur_st   = start_acc ? (type_ok ? ST_DECODE : ST_SKIP) : state_q;
  assign base     = start_acc ? '0 : offset_q;
  assign dec_beat = live && (cur_st == ST_DECODE);
  assign last_dec = dec_beat && in_last;

  // Count kept lanes; keep is contiguous so this is the beat's byte count.
  always_comb begin
    nkeep = '0;
    for (int i = 0; i < LANES; i++) nkeep = nkeep + 4'(in_keep[i]);
  end

  assign total   = TOT_W'(base) + TOT_W'(nkeep);
  assign off_sum = (total > OFF_SAT) ? '1 : total[OFF_W-1:0];

  // A length arriving on this very cycle (including the last beat) still counts.
  assign len_have = (len_vld_q && !start_acc) || len_valid;
  assign len_eff  = (len_vld_q && !start_acc) ? len_q : len_value;
  assign rec_load = last_dec && len_have && (total == TOT_W'(len_eff)) && (total == exp_len);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    itch_lane_scatter #(.LANE(g), .OFF_W(OFF_W)) u_scatter (
      .base_i    (base),
      .lane_en_i (dec_beat && in_keep[g]),
      .we_o      (lane_we[g])
    );
  end

  // Merge per-lane write enables into the staging bytes; lanes never collide.
  always_comb begin
    stage_d = stage_q;
    for (int k = 0; k < STAGE_BYTES; k++) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_we[i][k]) stage_d[k] = in_data[8*i +: 8];
      end
    end
  end

  // Assemble big-endian record fields from staging, including the final beat's bytes.
  always_comb begin
    rec_ref = '0; rec_shares = '0; rec_stock = '0; rec_price = '0;
    for (int j = 0; j < LEN_ORDER_REF; j++) rec_ref[8*(LEN_ORDER_REF-1-j) +: 8] = stage_d[OFF_ORDER_REF+j];
    for (int j = 0; j < LEN_SHARES; j++)    rec_shares[8*(LEN_SHARES-1-j) +: 8] = stage_d[OFF_SHARES+j];
    for (int j = 0; j < LEN_STOCK; j++)     rec_stock[8*(LEN_STOCK-1-j) +: 8]   = stage_d[OFF_STOCK+j];
    for (int j = 0; j < LEN_PRICE; j++)     rec_price[8*(LEN_PRICE-1-j) +: 8]   = stage_d[OFF_PRICE+j];
`ifdef ADD_ORDER_MPID_EN
    rec_mpid = '0;
    for (int j = 0; j < LEN_MPID; j++)      rec_mpid[8*(LEN_MPID-1-j) +: 8]     = stage_d[OFF_MPID+j];
`endif
  end

  // Error priority: a restart mid-message hides whatever the new beat would report.
  always_comb begin
    err_d = ERR_NONE;
    if (start_acc && (state_q == ST_DECODE)) err_d = ERR_TRUNC;
    else if (last_dec && !len_have)          err_d = ERR_NO_LEN;
    else if (last_dec && !rec_load)          err_d = ERR_LEN_MISMATCH;
  end

  // Next FSM state, byte offset and length latch; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    len_vld_d = len_vld_q;
    len_d     = len_q;
    if (abort_in) begin
      state_d = ST_IDLE; offset_d = '0; len_vld_d = 1'b0; len_d = '0;
    end else begin
      if (start_acc) begin
        len_vld_d = len_valid; len_d = len_value;
      end else if ((state_q == ST_DECODE) && !len_vld_q && len_valid) begin
        len_vld_d = 1'b1; len_d = len_value;
      end
      if (live && (cur_st != ST_IDLE)) begin
        if (in_last) begin
          state_d = ST_IDLE; offset_d = '0; len_vld_d = 1'b0; len_d = '0;
        end else begin
          state_d = cur_st; offset_d = off_sum;
        end
      end
    end
  end

  // FSM, offset counter and length latch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE; offset_q <= '0; len_vld_q <= 1'b0; len_q <= '0;
    end else begin
      state_q <= state_d; offset_q <= offset_d; len_vld_q <= len_vld_d; len_q <= len_d;
    end
  end

  // Staging bytes, filled speculatively as the message streams in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGE_BYTES; k++) stage_q[k] <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Output record holds until taken; a new load can only happen when in_ready allowed the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0; out_ref_q <= '0; out_buy_q <= 1'b0; out_shares_q <= '0;
      out_stock_q <= '0; out_price_q <= '0; err_vld_q <= 1'b0; err_code_q <= '0;
`ifdef ADD_ORDER_MPID_EN
      out_mpid_q <= '0; out_is_mpid_q <= 1'b0;
`endif
    end else begin
      err_vld_q  <= (err_d != ERR_NONE);
      err_code_q <= err_d;
      if (rec_load) begin
        out_valid_q  <= 1'b1;
        out_ref_q    <= rec_ref;
        out_buy_q    <= (stage_d[OFF_SIDE] == SIDE_BUY);
        out_shares_q <= rec_shares;
        out_stock_q  <= rec_stock;
        out_price_q  <= rec_price;
`ifdef ADD_ORDER_MPID_EN
        out_mpid_q    <= typf_d ? rec_mpid : '0;
        out_is_mpid_q <= typf_d;
`endif
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_order_ref = out_ref_q;
  assign out_buy       = out_buy_q;
  assign out_shares    = out_shares_q;
  assign out_stock     = out_stock_q;
  assign out_price     = out_price_q;
  assign err_valid     = err_vld_q;
  assign err_code      = err_code_q;
`ifdef ADD_ORDER_MPID_EN
  assign out_mpid      = out_mpid_q;
  assign out_is_mpid   = out_is_mpid_q;
`endif

endmodule

// File: tb/tb_add_order_decoder_mlane.sv
// Directed bench for add_order_decoder_mlane: a LANES=2 instance for the main scenarios
// and a LANES=8 instance for the partial-keep last beat.
// Inputs driven on the falling edge; outputs compared on the falling edge.
module tb_add_order_decoder_mlane;

  localparam logic [63:0] EXP_REF   = 64'h0102030405060708;
  localparam logic [63:0] EXP_REF2  = 64'h1102030405060708;
  localparam logic [31:0] EXP_SHR   = 32'd100;
  localparam logic [63:0] EXP_STOCK = 64'h4141504C20202020;
  localparam logic [31:0] EXP_PRICE = 32'h000186A0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] in_data;
  logic [1:0]  in_keep;
  logic in_valid, in_ready, in_start, in_last, abort_in, len_valid, out_valid, out_ready;
  logic [5:0]  len_value;
  logic [63:0] out_order_ref, out_stock;
  logic        out_buy, err_valid;
  logic [31:0] out_shares, out_price;
  logic [1:0]  err_code;

  logic [63:0] d8_in_data;
  logic [7:0]  d8_in_keep;
  logic d8_in_valid, d8_in_ready, d8_in_start, d8_in_last, d8_len_valid, d8_out_valid, d8_err_valid;
  logic [5:0]  d8_len_value;
  logic [63:0] d8_order_ref, d8_stock;
  logic        d8_buy;
  logic [31:0] d8_shares, d8_price;
  logic [1:0]  d8_err_code;

`ifdef ADD_ORDER_MPID_EN
  logic [31:0] out_mpid, d8_mpid;
  logic        out_is_mpid, d8_is_mpid;
`endif

  add_order_decoder_mlane #(.LANES(2), .OFF_W(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_keep(in_keep), .in_valid(in_valid),
    .in_ready(in_ready), .in_start(in_start), .in_last(in_last), .abort_in(abort_in),
    .len_value(len_value), .len_valid(len_valid), .out_valid(out_valid), .out_ready(out_ready),
    .out_order_ref(out_order_ref), .out_buy(out_buy), .out_shares(out_shares),
    .out_stock(out_stock), .out_price(out_price),
`ifdef ADD_ORDER_MPID_EN
    .out_mpid(out_mpid), .out_is_mpid(out_is_mpid),
`endif
    .err_valid(err_valid), .err_code(err_code)
  );

  add_order_decoder_mlane #(.LANES(8), .OFF_W(6)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_data(d8_in_data), .in_keep(d8_in_keep), .in_valid(d8_in_valid),
    .in_ready(d8_in_ready), .in_start(d8_in_start), .in_last(d8_in_last), .abort_in(1'b0),
    .len_value(d8_len_value), .len_valid(d8_len_valid), .out_valid(d8_out_valid), .out_ready(1'b1),
    .out_order_ref(d8_order_ref), .out_buy(d8_buy), .out_shares(d8_shares),
    .out_stock(d8_stock), .out_price(d8_price),
`ifdef ADD_ORDER_MPID_EN
    .out_mpid(d8_mpid), .out_is_mpid(d8_is_mpid),
`endif
    .err_valid(d8_err_valid), .err_code(d8_err_code)
  );

  int tests = 0;
  int fails = 0;
  int rec_cnt = 0;
  int err_cnt = 0;
  logic [1:0] last_err = 2'd0;
  logic [7:0] msg [30];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill_msg(input logic [7:0] typ, input logic [7:0] ref0);
    logic [239:0] v;
    v = {typ, ref0, 56'h02030405060708, 8'h42, 32'd100, "AAPL    ", 32'h000186A0, "GSCO"};
    for (int i = 0; i < 30; i++) msg[i] = v[8*(29-i) +: 8];
  endtask

  // Stream msg into the LANES=2 instance; cut_beats>0 sends that many beats without in_last.
  task automatic send(input int nbytes, input int len_beat, input logic [5:0] lv,
                      input int abort_beat, input int cut_beats);
    int nb;
    int guard;
    nb = (cut_beats > 0) ? cut_beats : (nbytes + 1) / 2;
    for (int b = 0; b < nb; b++) begin
      in_data   = {msg[2*b+1], msg[2*b]};
      in_keep   = (2*b + 1 < nbytes) ? 2'b11 : 2'b01;
      in_valid  = 1'b1;
      in_start  = (b == 0);
      in_last   = (cut_beats == 0) && (b == nb - 1);
      len_valid = (b == len_beat);
      len_value = lv;
      abort_in  = (b == abort_beat);
      guard = 0;
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      check("in_ready_wait", in_ready, 1);
      @(negedge clk);
      if (b == abort_beat) break;
    end
    in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0; len_valid = 1'b0; abort_in = 1'b0;
  endtask

  // Count taken records and error pulses at the clock edge where they happen.
  always @(posedge clk) begin
    if (out_valid && out_ready) rec_cnt++;
    if (err_valid) begin
      err_cnt++;
      last_err = err_code;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int rc;
    int ec;
    int guard;
    in_data = '0; in_keep = '0; in_valid = 0; in_start = 0; in_last = 0; abort_in = 0;
    len_valid = 0; len_value = '0; out_ready = 1;
    d8_in_data = '0; d8_in_keep = '0; d8_in_valid = 0; d8_in_start = 0; d8_in_last = 0;
    d8_len_valid = 0; d8_len_value = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_code", err_code, 0);
    check("rst_order_ref", out_order_ref, 0);
    check("rst_price", out_price, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 'A' message, length on beat 3
    fill_msg(8'h41, 8'h01);
    send(26, 3, 6'd26, -1, 0);
    check("a1_valid", out_valid, 1);
    check("a1_ref", out_order_ref, EXP_REF);
    check("a1_buy", out_buy, 1);
    check("a1_shares", out_shares, EXP_SHR);
    check("a1_stock", out_stock, EXP_STOCK);
    check("a1_price", out_price, EXP_PRICE);
    check("a1_no_err", err_cnt, 0);
    @(negedge clk);
    check("a1_taken", rec_cnt, 1);
    check("a1_valid_drop", out_valid, 0);

    // Output held under backpressure, then a second record follows
    out_ready = 1'b0;
    rc = rec_cnt;
    send(26, 3, 6'd26, -1, 0);
    check("hold_first_valid", out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_ref", out_order_ref, EXP_REF);
      check("hold_in_ready", in_ready, 0);
    end
    check("hold_not_taken", rec_cnt, rc);
    out_ready = 1'b1;
    fill_msg(8'h41, 8'h11);
    send(26, 3, 6'd26, -1, 0);
    check("second_valid", out_valid, 1);
    check("second_ref", out_order_ref, EXP_REF2);
    @(negedge clk);
    check("both_taken", rec_cnt, rc + 2);

    // Length mismatch, then missing length
    fill_msg(8'h41, 8'h01);
    send(26, 3, 6'd30, -1, 0);
    check("mismatch_err_valid", err_valid, 1);
    check("mismatch_err_code", err_code, 1);
    check("mismatch_no_rec", out_valid, 0);
    @(negedge clk);
    check("err_one_cycle", err_valid, 0);
    send(26, -1, 6'd0, -1, 0);
    check("nolen_err_valid", err_valid, 1);
    check("nolen_err_code", err_code, 2);
    check("nolen_no_rec", out_valid, 0);
    @(negedge clk);

    // Single-beat message: start and last together, too short
    send(2, 0, 6'd2, -1, 0);
    check("single_err_code", err_code, 1);
    check("single_no_rec", out_valid, 0);
    @(negedge clk);

    // Wrong type is skipped silently, following 'A' decodes
    rc = rec_cnt; ec = err_cnt;
    fill_msg(8'h45, 8'h01);
    send(26, 3, 6'd26, -1, 0);
    @(negedge clk);
    check("skip_no_rec", rec_cnt, rc);
    check("skip_no_err", err_cnt, ec);
    check("skip_valid_low", out_valid, 0);
    fill_msg(8'h41, 8'h01);
    send(26, 3, 6'd26, -1, 0);
    check("after_skip_valid", out_valid, 1);
    check("after_skip_ref", out_order_ref, EXP_REF);
    check("after_skip_price", out_price, EXP_PRICE);
    @(negedge clk);

    // Restart at offset 12: truncation error, new message decodes fully
    ec = err_cnt;
    send(26, 3, 6'd26, -1, 6);
    send(26, 3, 6'd26, -1, 0);
    check("trunc_err_cnt", err_cnt, ec + 1);
    check("trunc_err_code", last_err, 3);
    check("trunc_new_valid", out_valid, 1);
    check("trunc_new_shares", out_shares, EXP_SHR);
    check("trunc_new_stock", out_stock, EXP_STOCK);
    @(negedge clk);

    // Abort at offset 20: nothing reported, next message fine
    rc = rec_cnt; ec = err_cnt;
    send(26, 3, 6'd26, 10, 0);
    repeat (3) @(negedge clk);
    check("abort_no_rec", rec_cnt, rc);
    check("abort_no_err", err_cnt, ec);
    check("abort_valid_low", out_valid, 0);
    send(26, 3, 6'd26, -1, 0);
    check("after_abort_ref", out_order_ref, EXP_REF);
    check("after_abort_buy", out_buy, 1);
    check("after_abort_err", err_cnt, ec);
    @(negedge clk);

    // Asynchronous reset mid-message discards it
    ec = err_cnt;
    send(26, 3, 6'd26, -1, 8);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send(26, 3, 6'd26, -1, 0);
    check("midrst_next_ref", out_order_ref, EXP_REF);
    check("midrst_no_err", err_cnt, ec);
    @(negedge clk);

    // LANES=8: four beats, last beat keeps two lanes
    for (int b = 0; b < 4; b++) begin
      for (int l = 0; l < 8; l++) begin
        d8_in_data[8*l +: 8] = (8*b + l < 26) ? msg[8*b + l] : 8'h00;
        d8_in_keep[l]        = (8*b + l < 26);
      end
      d8_in_valid = 1'b1; d8_in_start = (b == 0); d8_in_last = (b == 3);
      d8_len_valid = (b == 0); d8_len_value = 6'd26;
      guard = 0;
      while (!d8_in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      check("d8_in_ready_wait", d8_in_ready, 1);
      @(negedge clk);
    end
    d8_in_valid = 1'b0; d8_in_start = 1'b0; d8_in_last = 1'b0; d8_len_valid = 1'b0;
    check("d8_keep_last", d8_in_keep, 8'h03);
    check("d8_valid", d8_out_valid, 1);
    check("d8_ref", d8_order_ref, EXP_REF);
    check("d8_buy", d8_buy, 1);
    check("d8_shares", d8_shares, EXP_SHR);
    check("d8_stock", d8_stock, EXP_STOCK);
    check("d8_price", d8_price, EXP_PRICE);
    check("d8_no_err", {d8_err_valid, d8_err_code}, 0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
